cbrt: RTL and testbench

- Sequential unsigned integer cube-root unit: y = floor(cbrt(x_i)) for 8-bit x_i.
- Uses the restoring bit-pair algorithm over 3 iterations.
- Each iteration needs one product from the shared sequential multiplier "mul", reached through a start/busy handshake.
- Sits as a start/busy-controlled arithmetic coprocessor. Result is held on y until the next operation.

---
 rtl/cbrt.sv | 205 ++++++++++++++++++++
 tb/tb_cbrt.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cbrt.sv
// cbrt: sequential unsigned 8-bit integer cube root, y = floor(cbrt(x_i)).
// Restoring bit-pair algorithm, 3 iterations. Each iteration takes one product
// y_acc*(y_acc+1) from the shared sequential multiplier cbrt_mul.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset (also resets the multiplier)
//   start - operation request, sampled only while busy = 0
//   x_i   - 8-bit unsigned operand, captured on the accepting edge
//   y     - registered floor cube root (0..6), held until the next DONE/reset
//   busy  - high from the edge after acceptance until the result is written

// Shift-add multiplier: busy rises the edge after start, result valid once busy falls.
module cbrt_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result,
    output logic        busy
);
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // One partial product per cycle, LSB of the multiplier first.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) busy_d = 1'b0;
        end else if (start) begin
            mcand_d  = {8'd0, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end
    end

    assign result = acc_q;
    assign busy   = busy_q;
endmodule

module cbrt (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] x_i,
    output logic [7:0] y,
    output logic       busy
);
    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 8;
    localparam int unsigned P_W = 16;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] MSTART = 3'd2;
    localparam logic [2:0] MWAIT  = 3'd3;
    localparam logic [2:0] CALC   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [X_W-1:0] xr_q, xr_d;
    logic [Y_W-1:0] yacc_q, yacc_d;
    logic [2:0]     s_q, s_d;
    logic           seen_q, seen_d;
    logic [P_W-1:0] p_q, p_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           busy_q, busy_d;
    logic           mstart_q, mstart_d;

    logic [P_W-1:0] mul_result;
    logic           mul_busy;
    logic [P_W-1:0] p3_c;
    logic [P_W-1:0] b_c;

    cbrt_mul u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mstart_q),
        .a      (yacc_q),
        .b      (yacc_q + 8'd1),
        .result (mul_result),
        .busy   (mul_busy)
    );

    // Trial subtrahend (3*y*(y+1) + 1) << s; 3*p by shift-add, full 16-bit width.
    always_comb begin
        p3_c = (p_q << 1) + p_q;
        b_c  = (p3_c + 16'd1) << s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            xr_q     <= '0;
            yacc_q   <= '0;
            s_q      <= '0;
            seen_q   <= 1'b0;
            p_q      <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            mstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            yacc_q   <= yacc_d;
            s_q      <= s_d;
            seen_q   <= seen_d;
            p_q      <= p_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            mstart_q <= mstart_d;
        end
    end

    // Next-state logic; mul start is registered so it is high for the whole MSTART cycle only.
    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        yacc_d   = yacc_q;
        s_d      = s_q;
        seen_d   = seen_q;
        p_d      = p_q;
        y_d      = y_q;
        busy_d   = busy_q;
        mstart_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = x_i;
                    yacc_d  = '0;
                    s_d     = 3'd6;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                yacc_d   = yacc_q << 1;
                mstart_d = 1'b1;
                state_d  = MSTART;
            end
            MSTART: begin
                seen_d  = 1'b0;
                state_d = MWAIT;
            end
            MWAIT: begin
                // Latency-agnostic: wait for busy to be seen high, then low.
                if (mul_busy) seen_d = 1'b1;
                if (seen_q && !mul_busy) begin
                    p_d     = mul_result;
                    state_d = CALC;
                end
            end
            CALC: begin
                if ({8'd0, xr_q} >= b_c) begin
                    xr_d   = xr_q - X_W'(b_c);
                    yacc_d = yacc_q + 8'd1;
                end
                if (s_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    s_d     = s_q - 3'd3;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                y_d     = yacc_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign y    = y_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_cbrt.sv
// Self-checking bench for cbrt: stimulus pushes expected roots into a queue,
// a negedge monitor pops and compares whenever busy falls.
module tb_cbrt;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x_i;
    logic [7:0] y;
    logic       busy;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int width_cnt = 0;
    int ref_width = -1;
    logic busy_prev = 1'b0;
    logic [7:0] exp_q[$];

    cbrt dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_i   (x_i),
        .y     (y),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each busy fall compare y against the queued expectation and the pulse width.
    always @(negedge clk) begin
        if (rst) begin
            width_cnt = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy) width_cnt++;
            if (busy_prev && !busy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got y=%0d with no expectation queued", y);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (y !== e) begin
                        bad++;
                        $display("FAIL result: got y=%0d want %0d", y, e);
                    end
                end
                if (ref_width < 0) begin
                    ref_width = width_cnt;
                end else begin
                    total++;
                    if (width_cnt != ref_width) begin
                        bad++;
                        $display("FAIL busy_width: got %0d want %0d", width_cnt, ref_width);
                    end
                end
                width_cnt = 0;
                done_cnt++;
            end
            busy_prev = busy;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) return;
        end
        total++;
        bad++;
        $display("FAIL timeout: done_cnt=%0d want %0d", done_cnt, target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_y", int'(y), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run(input int x, input int e);
        int t;
        t = done_cnt + 1;
        @(posedge clk);
        #2;
        start = 1'b1;
        x_i   = 8'(x);
        exp_q.push_back(8'(e));
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(t);
    endtask

    int basic_x[6]  = '{0, 1, 2, 8, 15, 27};
    int basic_y[6]  = '{0, 1, 1, 2, 2, 3};
    int upper_x[8]  = '{63, 64, 124, 125, 200, 215, 216, 255};
    int upper_y[8]  = '{3, 4, 4, 5, 5, 5, 6, 6};

    initial begin
        int t;
        int k;
        rst   = 1'b1;
        start = 1'b0;
        x_i   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("por_busy", int'(busy), 0);
        chk("por_y", int'(y), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        foreach (basic_x[i]) begin
            do_reset();
            run(basic_x[i], basic_y[i]);
        end

        foreach (upper_x[i]) run(upper_x[i], upper_y[i]);

        run(7, 1);
        run(26, 2);
        repeat (20) @(negedge clk);
        #1;
        chk("hold_y", int'(y), 2);
        chk("hold_busy", int'(busy), 0);

        for (int x = 0; x < 256; x++) begin
            k = 0;
            while ((k + 1) * (k + 1) * (k + 1) <= x) k++;
            run(x, k);
        end

        // start held high with x_i changing mid-operation; second op accepted right after busy falls.
        t = done_cnt;
        @(posedge clk);
        #2;
        start = 1'b1;
        x_i   = 8'd27;
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd6);
        @(posedge clk);
        #2;
        x_i = 8'd255;
        wait_done(t + 1);
        @(posedge clk);
        #1;
        chk("b2b_accept_busy", int'(busy), 1);
        start = 1'b0;
        wait_done(t + 2);

        // Reset mid-operation discards the partial result.
        @(posedge clk);
        #2;
        start = 1'b1;
        x_i   = 8'd125;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_y", int'(y), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        run(125, 5);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
